// File: rtl/output_subsystem_if.sv
// Bundle of print-job control, memory read port and serial status signals.
// The slave side is the print engine; the master side is the sequencer and memory.
interface output_subsystem_if;
    logic        w_en_output;
    logic [7:0]  w_count;
    logic        w_output_rd;
    logic [7:0]  w_output_addr;
    logic [31:0] w_output_data;
    logic        uart_tx;
    logic        w_busy;
    logic        w_tx_done;

    modport master (
        output w_en_output, w_count, w_output_data,
        input  w_output_rd, w_output_addr, uart_tx, w_busy, w_tx_done
    );

    modport slave (
        input  w_en_output, w_count, w_output_data,
        output w_output_rd, w_output_addr, uart_tx, w_busy, w_tx_done
    );
endinterface

// File: rtl/output_subsystem.sv
// Reads stored words, prints them as unsigned decimal ASCII with space separators
// and a CR/LF trailer, and transmits each byte on an 8N1 serial line.
module output_subsystem #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input logic              clk,
    input logic              rst_n,
    output_subsystem_if.slave bus
);
    localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(BIT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_CONV, S_SEP, S_CR, S_LF, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        count_q, count_d;
    logic [31:0]       val_q, val_d;
    logic [3:0]        pow_idx_q, pow_idx_d;
    logic [3:0]        digit_q, digit_d;
    logic              digit_rdy_q, digit_rdy_d;
    logic              started_q, started_d;
    logic              lf_sent_q, lf_sent_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tx_q, tx_d;
    logic              tx_busy_q, tx_busy_d;
    logic [9:0]        frame_q, frame_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;

    logic              tx_load;
    logic [7:0]        tx_byte;
    logic              conv_next;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd9:    return 32'd1_000_000_000;
            4'd8:    return 32'd100_000_000;
            4'd7:    return 32'd10_000_000;
            4'd6:    return 32'd1_000_000;
            4'd5:    return 32'd100_000;
            4'd4:    return 32'd10_000;
            4'd3:    return 32'd1_000;
            4'd2:    return 32'd100;
            4'd1:    return 32'd10;
            default: return 32'd1;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        val_d       = val_q;
        pow_idx_d   = pow_idx_q;
        digit_d     = digit_q;
        digit_rdy_d = digit_rdy_q;
        started_d   = started_q;
        lf_sent_d   = lf_sent_q;
        done_d      = 1'b0;
        tx_d        = tx_q;
        tx_busy_d   = tx_busy_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        clk_cnt_d   = clk_cnt_q;
        tx_load     = 1'b0;
        tx_byte     = 8'h00;
        conv_next   = 1'b0;

        // Serializer: frame_q[1] is always the next bit to drive
        if (tx_busy_q) begin
            if (clk_cnt_q == LAST_CLK) begin
                clk_cnt_d = '0;
                if (bit_cnt_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_d      = 1'b1;
                    bit_cnt_d = 4'd0;
                    frame_d   = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tx_d      = frame_q[1];
                    frame_d   = {1'b0, frame_q[9:1]};
                end
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.w_en_output) begin
                    count_d = bus.w_count;
                    addr_d  = 8'd1;
                    state_d = (bus.w_count == 8'd0) ? S_CR : S_READ;
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: begin
                val_d       = bus.w_output_data;
                pow_idx_d   = 4'd9;
                digit_d     = 4'd0;
                digit_rdy_d = 1'b0;
                started_d   = 1'b0;
                state_d     = S_CONV;
            end
            S_CONV: begin
                if (!digit_rdy_q) begin
                    if (val_q >= pow10(pow_idx_q)) begin
                        val_d   = val_q - pow10(pow_idx_q);
                        digit_d = digit_q + 4'd1;
                    end else begin
                        digit_rdy_d = 1'b1;
                    end
                end else if (digit_q != 4'd0 || started_q || pow_idx_q == 4'd0) begin
                    if (!tx_busy_q) begin
                        tx_load   = 1'b1;
                        tx_byte   = 8'h30 + {4'h0, digit_q};
                        started_d = 1'b1;
                        conv_next = 1'b1;
                    end
                end else begin
                    conv_next = 1'b1;
                end
                if (conv_next) begin
                    if (pow_idx_q == 4'd0) begin
                        state_d = (addr_q < count_q) ? S_SEP : S_CR;
                    end else begin
                        pow_idx_d   = pow_idx_q - 4'd1;
                        digit_d     = 4'd0;
                        digit_rdy_d = 1'b0;
                    end
                end
            end
            S_SEP: begin
                if (!tx_busy_q) begin
                    tx_load = 1'b1;
                    tx_byte = 8'h20;
                    addr_d  = addr_q + 8'd1;
                    state_d = S_READ;
                end
            end
            S_CR: begin
                if (!tx_busy_q) begin
                    tx_load   = 1'b1;
                    tx_byte   = 8'h0D;
                    lf_sent_d = 1'b0;
                    state_d   = S_LF;
                end
            end
            S_LF: begin
                // Completion waits for the LF stop bit so w_busy covers the whole job.
                if (!lf_sent_q) begin
                    if (!tx_busy_q) begin
                        tx_load   = 1'b1;
                        tx_byte   = 8'h0A;
                        lf_sent_d = 1'b1;
                    end
                end else if (!tx_busy_q) begin
                    lf_sent_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.w_en_output) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (tx_load) begin
            tx_busy_d = 1'b1;
            tx_d      = 1'b0;
            frame_d   = {1'b1, tx_byte, 1'b0};
            bit_cnt_d = 4'd0;
            clk_cnt_d = '0;
        end

        // Abort: drop the job and any frame in flight, line back to idle high
        if (!bus.w_en_output && state_q != S_IDLE && state_q != S_DONE) begin
            state_d     = S_IDLE;
            addr_d      = 8'd0;
            count_d     = 8'd0;
            val_d       = 32'd0;
            pow_idx_d   = 4'd0;
            digit_d     = 4'd0;
            digit_rdy_d = 1'b0;
            started_d   = 1'b0;
            lf_sent_d   = 1'b0;
            done_d      = 1'b0;
            tx_d        = 1'b1;
            tx_busy_d   = 1'b0;
            frame_d     = '0;
            bit_cnt_d   = 4'd0;
            clk_cnt_d   = '0;
        end

        rd_d   = (state_d == S_READ);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 8'd0;
            count_q     <= 8'd0;
            val_q       <= 32'd0;
            pow_idx_q   <= 4'd0;
            digit_q     <= 4'd0;
            digit_rdy_q <= 1'b0;
            started_q   <= 1'b0;
            lf_sent_q   <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            frame_q     <= '0;
            bit_cnt_q   <= 4'd0;
            clk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            val_q       <= val_d;
            pow_idx_q   <= pow_idx_d;
            digit_q     <= digit_d;
            digit_rdy_q <= digit_rdy_d;
            started_q   <= started_d;
            lf_sent_q   <= lf_sent_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            clk_cnt_q   <= clk_cnt_d;
        end
    end

    assign bus.w_output_rd   = rd_q;
    assign bus.w_output_addr = addr_q;
    assign bus.uart_tx       = tx_q;
    assign bus.w_busy        = busy_q;
    assign bus.w_tx_done     = done_q;
endmodule

// File: doc/output_subsystem.md
OUTPUT_SUBSYSTEM -- requirements
Module: output_subsystem

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate; bit period BIT_CLKS = CLK_FREQ/BAUD_RATE clocks, integer-truncated.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 w_en_output  input  1  level enable from the FSM; rising from idle starts a print job; low aborts.
REQ-006 w_count  input  8  number of stored words to print; sampled at job start.
REQ-007 w_output_rd  output  1  memory read strobe, one cycle per word.
REQ-008 w_output_addr  output  8  memory read address.
REQ-009 w_output_data  input  32  read data, valid exactly one cycle after w_output_rd.
REQ-010 uart_tx  output  1  serial line, 8N1, idle high.
REQ-011 w_busy  output  1  high while a job is in progress (any state except IDLE and DONE).
REQ-012 w_tx_done  output  1  one-cycle pulse when a job completes normally.

Function
REQ-013 The job SHALL print words at addresses 1..w_count as unsigned decimal ASCII, separated by one space (0x20), with no trailing space, followed by CR (0x0D) and LF (0x0A).
REQ-014 When w_count = 0, the job SHALL emit only CR, LF.
REQ-015 Main FSM states SHALL be IDLE, READ, LATCH, CONV, SEP, CR, LF, and DONE.
REQ-016 IDLE -> READ when w_en_output = 1; set addr = 1 and latch w_count; with a count of 0, go IDLE -> CR instead.
REQ-017 READ: assert w_output_rd for one cycle; LATCH: capture w_output_data the next cycle.
REQ-018 CONV SHALL extract digits MSB-first by repeated subtraction of 10^9 down to 10^0; at most 9 subtractions per power.
REQ-019 CONV SHALL suppress leading zeros; the 10^0 digit is always emitted, so a value of 0 prints "0".
REQ-020 Each digit SHALL be sent as 0x30+d before the next power is processed.
REQ-021 All 32-bit values (0..4294967295) SHALL print correctly; arithmetic is unsigned 32-bit with no overflow.
REQ-022 After the last digit: if addr < count, go to SEP (send 0x20), then addr+1, then READ; otherwise go to CR.
REQ-023 After LF, the FSM SHALL go to DONE and pulse w_tx_done for exactly 1 cycle; it stays in DONE until w_en_output = 0, then returns to IDLE, so there is no repeat job.
REQ-024 Serializer frame: start bit 0, data bits LSB first, stop bit 1, each held exactly BIT_CLKS cycles.
REQ-025 Frames SHALL never overlap; the next byte is loaded only after the full stop bit, and uart_tx is held high in any gap between frames.
REQ-026 w_en_output = 0 in any state other than IDLE/DONE SHALL abort within 1 cycle: uart_tx = 1, w_busy = 0, w_output_rd = 0, state IDLE, no w_tx_done; a truncated frame is acceptable.
REQ-027 w_count changes during a job SHALL be ignored.

Reset
REQ-028 rst_n low SHALL act immediately, including mid-frame: state IDLE, uart_tx = 1, w_output_rd = 0, w_output_addr = 0, w_busy = 0, w_tx_done = 0, and all counters and data registers = 0.
REQ-029 After reset release, no output SHALL change until w_en_output = 1.

Verification
REQ-030 count=1, mem[1]=0 -> bytes 0x30,0x0D,0x0A on uart_tx; then one w_tx_done pulse.
REQ-031 count=3, mem = {7, 120, 4294967295} -> ASCII "7 120 4294967295\r\n"; read addresses 1, 2, 3 in order.
REQ-032 CLK_FREQ=1000, BAUD_RATE=100, byte 0x31 -> low 10 clks, then bits 1,0,0,0,1,1,0,0 at 10 clks each, then high 10 clks.
REQ-033 count=0 -> 0x0D,0x0A only, no w_output_rd pulses, w_tx_done pulses.
REQ-034 w_en_output dropped mid-frame -> next cycle uart_tx = 1, w_busy = 0, no w_tx_done; re-enable restarts at addr 1.
REQ-035 rst_n asserted during digit transmission -> all outputs at reset values asynchronously; w_en_output held high through release starts a fresh job from addr 1.
